// File: rtl/ddr3_pkg.sv
// Shared DDR3 definitions: command codes, mode-register field encodings,
// JEDEC timing defaults and the init/refresh sequencer state type.
package ddr3_pkg;

  // {RAS_N, CAS_N, WE_N} command encodings (CS_N is driven at the top level)
  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_ZQC = 3'b110;
  localparam logic [2:0] CMD_NOP = 3'b111;

  // A10 selects ZQCL (long calibration) on a ZQC command
  localparam int ZQ_A10_BIT = 10;

  // MR0 field encodings
  localparam logic [1:0] MR0_BL8_FIXED = 2'b00;
  localparam logic [1:0] MR0_BL_OTF    = 2'b01;
  localparam logic [1:0] MR0_BC4_FIXED = 2'b10;
  localparam logic [3:0] MR0_CL5       = 4'b0010;
  localparam logic [3:0] MR0_CL6       = 4'b0100;
  localparam logic [3:0] MR0_CL7       = 4'b0110;
  localparam logic [3:0] MR0_CL11      = 4'b1110;
  localparam logic [2:0] MR0_WR5       = 3'b001;
  localparam logic [2:0] MR0_WR6       = 3'b010;
  localparam logic [2:0] MR0_WR8       = 3'b100;
  localparam logic [2:0] MR0_WR12      = 3'b110;

  // JEDEC defaults in controller cycles, 2Gb density
  // DDR3-800 (400 MHz)
  localparam int DDR3_800_TXPR    = 68;
  localparam int DDR3_800_TRFC    = 64;
  localparam int DDR3_800_TREFI   = 3120;
  // DDR3-1066 (533 MHz)
  localparam int DDR3_1066_TXPR   = 91;
  localparam int DDR3_1066_TRFC   = 86;
  localparam int DDR3_1066_TREFI  = 4160;
  // DDR3-1600 (800 MHz)
  localparam int DDR3_1600_TXPR   = 136;
  localparam int DDR3_1600_TRFC   = 128;
  localparam int DDR3_1600_TREFI  = 6240;

  // Each MRS/ZQ state holds the spacing that follows that command
  typedef enum logic [3:0] {
    ST_RESET_HOLD = 4'd0,
    ST_CKE_WAIT   = 4'd1,
    ST_TXPR_WAIT  = 4'd2,
    ST_MRS2       = 4'd3,
    ST_MRS3       = 4'd4,
    ST_MRS1       = 4'd5,
    ST_MRS0       = 4'd6,
    ST_ZQ_WAIT    = 4'd7,
    ST_IDLE       = 4'd8,
    ST_REF_WAIT   = 4'd9
  } init_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_init_ref_ctrl_if.sv
// Command port plus refresh arbiter handshake between the sequencer and the
// top-level command mux / arbiter.
interface ddr3_init_ref_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 3
) ();
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [BA_W-1:0]   ba;
  logic [ADDR_W-1:0] addr;
  logic              ref_req;
  logic              ref_gnt;
  logic              ref_urgent;
  logic              ref_overflow;

  modport master (
    output cmd_valid, cmd, ba, addr, ref_req, ref_urgent, ref_overflow,
    input  ref_gnt
  );

  modport slave (
    input  cmd_valid, cmd, ba, addr, ref_req, ref_urgent, ref_overflow,
    output ref_gnt
  );
endinterface

// File: rtl/ddr3_ref_sched.sv
// Post-init refresh scheduler: tREFI timer, saturating pending count,
// request/urgent/overflow flags and grant acceptance.
module ddr3_ref_sched #(
  parameter int TREFI_CYC    = 3120,
  parameter int MAX_POSTPONE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic init_fire,   // init sequence completes on this edge
  input  logic ref_done,    // tRFC spacing ends on this edge
  input  logic ref_gnt,
  output logic ref_take,    // grant accepted: REF goes out on this edge
  output logic ref_req,
  output logic ref_urgent,
  output logic ref_overflow
);
  localparam int REFI_W = $clog2(TREFI_CYC) + 1;
  localparam int PEND_W = $clog2(MAX_POSTPONE + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_POSTPONE);

  logic              active;
  logic              bus_idle;
  logic [REFI_W-1:0] refi_cnt;
  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pending_next;
  logic              idle_next;
  logic              expire;

  assign expire   = active && (refi_cnt == {REFI_W{1'b0}});
  assign ref_take = ref_req && ref_gnt;

  // Next pending count: expiry adds, accepted grant removes, both cancel
  always_comb begin
    pending_next = pending;
    if (expire && !ref_take) begin
      if (pending != PEND_MAX) begin
        pending_next = pending + PEND_W'(1);
      end else begin
        pending_next = pending;
      end
    end else if (ref_take && !expire) begin
      pending_next = pending - PEND_W'(1);
    end else begin
      pending_next = pending;
    end
  end

  // Bus ownership: free after init and after tRFC, busy once REF is taken
  always_comb begin
    idle_next = bus_idle;
    if (init_fire || ref_done) begin
      idle_next = 1'b1;
    end else if (ref_take) begin
      idle_next = 1'b0;
    end else begin
      idle_next = bus_idle;
    end
  end

  // Timer, pending count and registered request/status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= 1'b0;
      bus_idle     <= 1'b0;
      refi_cnt     <= {REFI_W{1'b0}};
      pending      <= {PEND_W{1'b0}};
      ref_req      <= 1'b0;
      ref_urgent   <= 1'b0;
      ref_overflow <= 1'b0;
    end else begin
      if (init_fire) begin
        active   <= 1'b1;
        refi_cnt <= REFI_W'(TREFI_CYC - 1);
      end else if (expire) begin
        refi_cnt <= REFI_W'(TREFI_CYC - 1);
      end else if (active) begin
        refi_cnt <= refi_cnt - REFI_W'(1);
      end
      pending    <= pending_next;
      bus_idle   <= idle_next;
      ref_req    <= (pending_next != {PEND_W{1'b0}}) && idle_next;
      ref_urgent <= (pending_next == PEND_MAX);
      if (expire && (pending == PEND_MAX)) begin
        ref_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ddr3_init_ref_ctrl.sv
// DDR3 power-up sequencer (reset/CKE/MRS/ZQCL) with post-init refresh issue.
module ddr3_init_ref_ctrl
  import ddr3_pkg::*;
#(
  parameter int          ADDR_W       = 13,
  parameter int          BA_W         = 3,
  parameter int          T_RESET_CYC  = 80000,
  parameter int          T_CKE_CYC    = 200000,
  parameter int          TXPR_CYC     = 48,
  parameter int          TMRD_CYC     = 4,
  parameter int          TMOD_CYC     = 12,
  parameter int          TZQINIT_CYC  = 512,
  parameter int          TRFC_CYC     = 44,
  parameter int          TREFI_CYC    = 3120,
  parameter logic [13:0] MR0          = 14'h0520,
  parameter logic [13:0] MR1          = 14'h0000,
  parameter logic [13:0] MR2          = 14'h0000,
  parameter logic [13:0] MR3          = 14'h0000,
  parameter int          MAX_POSTPONE = 8
) (
  input  logic clk,
  input  logic rst,
  output logic ddr_rst_n,
  output logic cke,
  output logic odt,
  output logic init_done,
  ddr3_init_ref_ctrl_if.master bus
);
  localparam int T_MAX = max2(max2(max2(T_RESET_CYC, T_CKE_CYC), max2(TXPR_CYC, TMRD_CYC)),
                              max2(max2(TMOD_CYC, TZQINIT_CYC), max2(TRFC_CYC, TREFI_CYC)));
  localparam int CNT_W = $clog2(T_MAX) + 1;
  localparam logic [ADDR_W-1:0] ZQ_ADDR = ADDR_W'(32'd1 << ZQ_A10_BIT);

  init_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             init_fire;
  logic             ref_done;
  logic             ref_take;

  assign cnt_zero  = (cnt == {CNT_W{1'b0}});
  assign init_fire = (state == ST_ZQ_WAIT) && cnt_zero;
  assign ref_done  = (state == ST_REF_WAIT) && cnt_zero;
  assign odt       = 1'b0;

  ddr3_ref_sched #(
    .TREFI_CYC   (TREFI_CYC),
    .MAX_POSTPONE(MAX_POSTPONE)
  ) u_ref_sched (
    .clk         (clk),
    .rst         (rst),
    .init_fire   (init_fire),
    .ref_done    (ref_done),
    .ref_gnt     (bus.ref_gnt),
    .ref_take    (ref_take),
    .ref_req     (bus.ref_req),
    .ref_urgent  (bus.ref_urgent),
    .ref_overflow(bus.ref_overflow)
  );

  // Sequencer FSM: one shared wait counter, one-cycle registered commands
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RESET_HOLD;
      cnt           <= CNT_W'(T_RESET_CYC - 1);
      ddr_rst_n     <= 1'b0;
      cke           <= 1'b0;
      init_done     <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.cmd       <= CMD_NOP;
      bus.ba        <= {BA_W{1'b0}};
      bus.addr      <= {ADDR_W{1'b0}};
    end else begin
      bus.cmd_valid <= 1'b0;
      bus.cmd       <= CMD_NOP;
      bus.ba        <= {BA_W{1'b0}};
      bus.addr      <= {ADDR_W{1'b0}};
      if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end
      case (state)
        ST_RESET_HOLD: if (cnt_zero) begin
          ddr_rst_n <= 1'b1;
          cnt       <= CNT_W'(T_CKE_CYC - 1);
          state     <= ST_CKE_WAIT;
        end
        ST_CKE_WAIT: if (cnt_zero) begin
          cke   <= 1'b1;
          cnt   <= CNT_W'(TXPR_CYC - 1);
          state <= ST_TXPR_WAIT;
        end
        ST_TXPR_WAIT: if (cnt_zero) begin
          bus.cmd_valid <= 1'b1;
          bus.cmd       <= CMD_MRS;
          bus.ba        <= BA_W'(2);
          bus.addr      <= ADDR_W'(MR2);
          cnt           <= CNT_W'(TMRD_CYC - 1);
          state         <= ST_MRS2;
        end
        ST_MRS2: if (cnt_zero) begin
          bus.cmd_valid <= 1'b1;
          bus.cmd       <= CMD_MRS;
          bus.ba        <= BA_W'(3);
          bus.addr      <= ADDR_W'(MR3);
          cnt           <= CNT_W'(TMRD_CYC - 1);
          state         <= ST_MRS3;
        end
        ST_MRS3: if (cnt_zero) begin
          bus.cmd_valid <= 1'b1;
          bus.cmd       <= CMD_MRS;
          bus.ba        <= BA_W'(1);
          bus.addr      <= ADDR_W'(MR1);
          cnt           <= CNT_W'(TMRD_CYC - 1);
          state         <= ST_MRS1;
        end
        ST_MRS1: if (cnt_zero) begin
          bus.cmd_valid <= 1'b1;
          bus.cmd       <= CMD_MRS;
          bus.ba        <= BA_W'(0);
          bus.addr      <= ADDR_W'(MR0);
          cnt           <= CNT_W'(TMOD_CYC - 1);
          state         <= ST_MRS0;
        end
        ST_MRS0: if (cnt_zero) begin
          bus.cmd_valid <= 1'b1;
          bus.cmd       <= CMD_ZQC;
          bus.addr      <= ZQ_ADDR;
          cnt           <= CNT_W'(TZQINIT_CYC - 1);
          state         <= ST_ZQ_WAIT;
        end
        ST_ZQ_WAIT: if (cnt_zero) begin
          init_done <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_IDLE: if (ref_take) begin
          bus.cmd_valid <= 1'b1;
          bus.cmd       <= CMD_REF;
          cnt           <= CNT_W'(TRFC_CYC - 1);
          state         <= ST_REF_WAIT;
        end
        ST_REF_WAIT: if (cnt_zero) begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_RESET_HOLD;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ddr3_init_ref_ctrl.sv
// Directed bench for ddr3_init_ref_ctrl with an edge-time reference model.
module tb_ddr3_init_ref_ctrl;
  localparam int TR = 4, TC = 5, TXPR = 6, TMRD = 4, TMOD = 12, TZQ = 8;
  localparam int TRFC = 10, TREFI = 20, MAXP = 2;
  localparam logic [12:0] M0 = 13'h1D70, M1 = 13'h0044, M2 = 13'h0008, M3 = 13'h0002;
  localparam int T_MRS2 = TR + TC + TXPR;
  localparam int T_ZQ   = T_MRS2 + 3 * TMRD + TMOD;
  localparam int T_INIT = T_ZQ + TZQ;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ddr_rst_n, cke, odt, init_done;
  ddr3_init_ref_ctrl_if #(.ADDR_W(13), .BA_W(3)) bus ();

  ddr3_init_ref_ctrl #(
    .ADDR_W(13), .BA_W(3), .T_RESET_CYC(TR), .T_CKE_CYC(TC), .TXPR_CYC(TXPR),
    .TMRD_CYC(TMRD), .TMOD_CYC(TMOD), .TZQINIT_CYC(TZQ), .TRFC_CYC(TRFC),
    .TREFI_CYC(TREFI), .MR0({1'b0, M0}), .MR1({1'b0, M1}), .MR2({1'b0, M2}),
    .MR3({1'b0, M3}), .MAX_POSTPONE(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .ddr_rst_n(ddr_rst_n), .cke(cke), .odt(odt),
    .init_done(init_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int e = 0;            // edges since reset release
  int phase = 0;

  // model state
  int  pend = 0;
  int  busy_until = T_INIT;
  bit  m_req = 1'b0, m_urg = 1'b0, m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (phase %0d edge %0d): got %0h expected %0h", name, phase, e, act, exp);
    end
  endtask

  // Model advance and per-cycle compare at the falling edge
  initial begin
    bit take, expire, v;
    logic [2:0] c, b;
    logic [12:0] a;
    forever begin
      @(negedge clk);
      take = 1'b0;
      if (rst) begin
        e = 0; pend = 0; busy_until = T_INIT;
        m_req = 1'b0; m_urg = 1'b0; m_ovf = 1'b0;
      end else begin
        e++;
        take   = m_req && bus.ref_gnt;
        expire = (e > T_INIT) && (((e - T_INIT) % TREFI) == 0);
        if (expire && pend == MAXP) m_ovf = 1'b1;
        if (expire && !take) begin
          if (pend < MAXP) pend++;
        end else if (take && !expire) begin
          pend--;
        end
        if (take) busy_until = e + TRFC;
        m_req = (pend > 0) && (e >= busy_until);
        m_urg = (pend == MAXP);
      end
      v = 1'b0; c = 3'b111; b = 3'd0; a = 13'h0;
      if (!rst) begin
        if (e == T_MRS2)                 begin v = 1'b1; c = 3'b000; b = 3'd2; a = M2; end
        else if (e == T_MRS2 + TMRD)     begin v = 1'b1; c = 3'b000; b = 3'd3; a = M3; end
        else if (e == T_MRS2 + 2 * TMRD) begin v = 1'b1; c = 3'b000; b = 3'd1; a = M1; end
        else if (e == T_MRS2 + 3 * TMRD) begin v = 1'b1; c = 3'b000; b = 3'd0; a = M0; end
        else if (e == T_ZQ)              begin v = 1'b1; c = 3'b110; a = 13'h0400; end
        else if (take)                   begin v = 1'b1; c = 3'b001; end
      end
      check("ddr_rst_n", ddr_rst_n, !rst && e >= TR);
      check("cke", cke, !rst && e >= TR + TC);
      check("odt", odt, 1'b0);
      check("init_done", init_done, !rst && e >= T_INIT);
      check("cmd_valid", bus.cmd_valid, v);
      check("cmd", bus.cmd, c);
      check("ba", bus.ba, b);
      check("addr", bus.addr, a);
      check("ref_req", bus.ref_req, m_req);
      check("ref_urgent", bus.ref_urgent, m_urg);
      check("ref_overflow", bus.ref_overflow, m_ovf);
      // hand-computed timeline points
      if (rst) check("lit_reset", {ddr_rst_n, cke, bus.cmd_valid, bus.cmd, init_done, bus.ref_req}, {1'b0, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0});
      else begin
        if (e == 3)  check("lit_rst_n_low", ddr_rst_n, 1'b0);
        if (e == 4)  check("lit_rst_n_high", ddr_rst_n, 1'b1);
        if (e == 8)  check("lit_cke_low", cke, 1'b0);
        if (e == 9)  check("lit_cke_high", cke, 1'b1);
        if (e == 15) check("lit_mrs2", {bus.cmd_valid, bus.cmd, bus.ba}, {1'b1, 3'b000, 3'd2});
        if (e == 19) check("lit_mrs3", {bus.cmd_valid, bus.ba}, {1'b1, 3'd3});
        if (e == 23) check("lit_mrs1", {bus.cmd_valid, bus.ba}, {1'b1, 3'd1});
        if (e == 27) check("lit_mrs0", {bus.cmd_valid, bus.cmd, bus.ba, bus.addr}, {1'b1, 3'b000, 3'd0, 13'h1D70});
        if (e == 28) check("lit_mrs0_gone", {bus.cmd_valid, bus.addr}, {1'b0, 13'h0000});
        if (e == 39) check("lit_zqcl", {bus.cmd_valid, bus.cmd, bus.addr[10]}, {1'b1, 3'b110, 1'b1});
        if (e == 46) check("lit_init_low", init_done, 1'b0);
        if (e == 47) check("lit_init_high", init_done, 1'b1);
        if (phase == 1 && e == 67) check("lit_req67", bus.ref_req, 1'b1);
        if (phase == 1 && (e == 68 || e == 88)) check("lit_ref", {bus.cmd_valid, bus.cmd}, {1'b1, 3'b001});
        if (phase == 1 && e == 69) check("lit_req_drop", bus.ref_req, 1'b0);
        if (phase == 2 && e == 86) check("lit_urg86", bus.ref_urgent, 1'b0);
        if (phase == 2 && e == 87) check("lit_urg87", bus.ref_urgent, 1'b1);
        if (phase == 2 && e == 107) check("lit_ovf", bus.ref_overflow, 1'b1);
        if (phase == 2 && (e == 109 || e == 120)) check("lit_pp_ref", {bus.cmd_valid, bus.cmd}, {1'b1, 3'b001});
        if (phase == 2 && e == 121) check("lit_pp_idle", bus.ref_req, 1'b0);
        if (phase == 2 && e == 140) check("lit_ovf_sticky", bus.ref_overflow, 1'b1);
        if (phase == 3 && e == 87) check("lit_sim_ref", {bus.cmd_valid, bus.cmd, bus.ref_req}, {1'b1, 3'b001, 1'b0});
        if (phase == 3 && e == 97) check("lit_sim_req", bus.ref_req, 1'b1);
      end
    end
  end

  task automatic run_until(input int n);
    int guard;
    guard = 0;
    while (e < n && guard < 2000) begin
      @(negedge clk); #1;
      guard++;
    end
    if (e < n) begin
      checks++; errors++;
      $display("FAIL run_until: reached edge %0d expected %0d", e, n);
    end
  endtask

  task automatic do_reset(input int ph);
    rst = 1'b1;
    bus.ref_gnt = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    phase = ph;
    rst = 1'b0;
  endtask

  // Stimulus
  initial begin
    bus.ref_gnt = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    // immediate grant, grant held high from power-up
    do_reset(1);
    bus.ref_gnt = 1'b1;
    run_until(100);
    // postponement to saturation and overflow, then drain
    do_reset(2);
    run_until(108);
    bus.ref_gnt = 1'b1;
    run_until(140);
    // grant coinciding with a tREFI expiry while one refresh is pending
    do_reset(3);
    run_until(86);
    bus.ref_gnt = 1'b1;
    run_until(87);
    bus.ref_gnt = 1'b0;
    run_until(110);
    // reset between MRS3 and MRS1, then full restart
    do_reset(4);
    run_until(20);
    rst = 1'b1;
    repeat (2) begin @(negedge clk); #1; end
    rst = 1'b0;
    run_until(50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr3_init_ref_ctrl.md
# ddr3_init_ref_ctrl

Parametrised DDR3 power-up sequencer and refresh scheduler: the next generation of the fixed-timing init controller. It adds:
- cycle-parameterised JEDEC timings;
- configurable MR0–MR3 values and address/bank widths;
- a post-init periodic refresh engine with postponement tracking and an arbiter handshake.

It owns the DRAM reset/CKE pins and drives a command port that the top-level command mux merges with the read/write datapath.

## Interface
Parameters:
- ADDR_W, 13, DRAM address width.
- BA_W, 3, bank address width.
- T_RESET_CYC, 80000, cycles ddr_rst_n held low (≥2).
- T_CKE_CYC, 200000, cycles from ddr_rst_n high to cke high (≥2).
- TXPR_CYC, 48, cycles from cke high to first MRS (≥2).
- TMRD_CYC, 4, MRS-to-MRS spacing (≥2).
- TMOD_CYC, 12, MRS0-to-ZQCL spacing (≥2).
- TZQINIT_CYC, 512, ZQCL-to-init_done spacing (≥2).
- TRFC_CYC, 44, REF-to-next-command spacing (≥2).
- TREFI_CYC, 3120, refresh interval (≥2).
- MR0..MR3, 14'h0520/0/0/0, mode register payloads; only ADDR_W LSBs are driven.
- MAX_POSTPONE, 8, pending-refresh saturation limit.

Ports (clk, rst first):
- clk in 1 — sole clock.
- rst in 1 — synchronous, active-high reset.
- ddr_rst_n out 1 — DRAM RESET#.
- cke out 1 — DRAM CKE.
- odt out 1 — tied low in this block.
- cmd_valid out 1 — cmd/ba/addr carry a real command this cycle.
- cmd out 3 — {RAS_N,CAS_N,WE_N}; NOP=111 when !cmd_valid.
- ba out BA_W — bank address.
- addr out ADDR_W — address.
- init_done out 1 — sequence complete; level, stays high until rst.
- ref_req out 1 — refresh pending, requesting the bus.
- ref_gnt in 1 — arbiter grant; the main controller guarantees all banks are precharged.
- ref_urgent out 1 — pending count == MAX_POSTPONE.
- ref_overflow out 1 — sticky error: TREFI expired while saturated.

## Operation
- Command codes: MRS=000, REF=001, ZQC=110, NOP=111. CS_N is asserted at the top level.
- State machine:
  - RESET_HOLD → CKE_WAIT → TXPR_WAIT → MRS2 → MRS3 → MRS1 → MRS0 → ZQCL → ZQ_WAIT → IDLE ⇄ REF_WAIT.
  - The MRS states issue one cycle-wide MRS. ba=2/3/1/0 with addr=MR2/MR3/MR1/MR0, in that order.
  - ZQCL issues cmd=110 with addr[10]=1.
- Wait counter:
  - A single down-counter, width $clog2 of the largest T_* parameter plus 1.
  - Loaded with T−1 when an event fires.
  - The next event fires on the cycle after it reads 0.
- Refresh sub-engine (active only when init_done=1):
  - The refi timer reloads to TREFI_CYC−1 on each expiry.
  - Each expiry does pending++ (saturating at MAX_POSTPONE); overflow sets ref_overflow.
  - ref_req = (pending≠0) && state==IDLE.
  - A grant while ref_req issues REF (ba=0, addr=0) on the next edge, does pending−−, enters REF_WAIT for TRFC_CYC, then returns to IDLE.
  - Same-cycle expiry and grant: pending is unchanged.
  - ref_gnt without ref_req is ignored.
- rst asserted at any point (including mid-MRS or REF_WAIT):
  - The next edge forces RESET_HOLD and all reset values.
  - The full sequence restarts.

## Timing
- Reset values:
  - ddr_rst_n=0, cke=0, odt=0.
  - cmd_valid=0, cmd=111, ba=0, addr=0.
  - init_done=0, ref_req=0, ref_urgent=0, ref_overflow=0.
  - Counters and pending are 0.
- Edge numbering: edge 1 is the first rising edge with rst=0. All outputs are registered.
- Init sequence (each event is N edges after the previous one):
  - ddr_rst_n rises after edge T_RESET_CYC.
  - cke rises T_CKE_CYC edges later.
  - MRS2 is issued TXPR_CYC later.
  - MRS3, MRS1 and MRS0 each follow the previous MRS by TMRD_CYC.
  - ZQCL follows MRS0 by TMOD_CYC.
  - init_done rises TZQINIT_CYC after ZQCL.
- The refi timer starts on the init_done edge. The first expiry is TREFI_CYC edges later, and ref_req rises on that same edge.
- Refresh handshake:
  - Grant sampled at edge k → REF with cmd_valid=1 for edge k+1 only, and ref_req=0 from edge k+1.
  - ref_req may reassert at k+1+TRFC_CYC if pending≠0.
- cmd_valid is high for exactly one cycle per command; ba/addr are valid only while cmd_valid=1 and return to 0 afterwards.

## Structure
- Shared package ddr3_pkg holds:
  - command-code localparams;
  - MR field helper constants (CL, WR, BL encodings);
  - the JEDEC default T_* values per speed grade.
- Sub-module ddr3_ref_sched holds the refi timer, the pending saturating counter, ref_req/urgent/overflow and the grant handshake. The top FSM owns REF issue and REF_WAIT.

## Test plan
Common parameters: T_RESET=4, T_CKE=5, TXPR=6, TMRD=4, TMOD=12, TZQINIT=8, TRFC=10, TREFI=20, MAX_POSTPONE=2.
- Power-up: release rst → ddr_rst_n high after edge 4, cke after 9. MRS ba=2/3/1/0 at edges 15/19/23/27. ZQCL addr[10]=1 at 39. init_done at 47.
- Immediate grant: hold ref_gnt=1 → ref_req at 67, REF at 68. Next REF at 88, 20 edges after the first REF at 68 and ≥TRFC apart.
- Postponement: ref_gnt=0 → ref_urgent at edge 87 (pending=2). ref_overflow at 107, sticky. Grant → two REFs spaced 11 edges, then ref_req low.
- Simultaneous expiry+grant with pending=1 → one REF issued, ref_req stays high afterward.
- Mid-sequence reset: assert rst at edge 21 (between MRS3 and MRS1) → next edge all outputs at reset values. On release the timeline repeats from edge 1.
- Custom MR0=13'h1D70 → addr=13'h1D70, ba=0, cmd=000 on the MRS0 cycle only.
